// File: rtl/lfsr_rr_server.sv
// lfsr_rr_server
//   Round-robin server that shares one 4-bit Fibonacci LFSR (period 15)
//   among NREQ requesters. Each grant carries the current LFSR value, and the
//   LFSR advances only when a grant is issued.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   clr        synchronous clear of LFSR, pointer and wrap counter
//   en         grants allowed when high; LFSR frozen when low
//   seed_load  load seed into the LFSR (zero seed maps to 4'b0001)
//   seed       seed value
//   req        level requests, one bit per requester
//   gnt        registered one-hot grant
//   gnt_valid  high exactly when gnt != 0
//   rnd        value delivered with gnt; held until the next grant
//   wrap       pulse with the grant completing 15 values since seed/clr/reset
//   busy       high while in SEED state
module lfsr_rr_server #(
  parameter int unsigned NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic            seed_load,
  input  logic [3:0]      seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [3:0]      rnd,
  output logic            wrap,
  output logic            busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    SEED  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      lfsr;
  logic [3:0]      lfsr_next;
  logic [3:0]      cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic            found;
  logic            grant;
  int unsigned     idx;

  assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  assign gnt_valid = |gnt;
  assign busy      = (state == SEED);

  // First set request searching ptr, ptr+1, ... modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!found && req[PW'(idx)]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  // Next state; a grant is issued exactly on edges whose target is SERVE.
  always_comb begin
    state_nxt = IDLE;
    grant     = 1'b0;
    if (clr) begin
      state_nxt = IDLE;
    end else if (seed_load) begin
      state_nxt = SEED;
    end else if (state == SEED) begin
      state_nxt = IDLE;
    end else if (en && found) begin
      state_nxt = SERVE;
      grant     = 1'b1;
    end else begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr <= 4'b0001;
      ptr  <= '0;
      cnt  <= '0;
      gnt  <= '0;
      rnd  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      lfsr <= 4'b0001;
      ptr  <= '0;
      cnt  <= '0;
      gnt  <= '0;
      wrap <= 1'b0;
    end else if (seed_load) begin
      lfsr <= (seed == 4'b0000) ? 4'b0001 : seed;
      cnt  <= '0;
      gnt  <= '0;
      wrap <= 1'b0;
    end else if (grant) begin
      gnt  <= NREQ'(1) << winner;
      rnd  <= lfsr;
      lfsr <= lfsr_next;
      ptr  <= (winner == PW'(NREQ - 1)) ? '0 : winner + PW'(1);
      wrap <= (cnt == 4'd14);
      cnt  <= (cnt == 4'd14) ? 4'd0 : cnt + 4'd1;
    end else begin
      gnt  <= '0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lfsr_rr_server.sv
module tb_lfsr_rr_server;

  logic       clk = 1'b0;
  logic       reset, clr, en, seed_load;
  logic [3:0] seed, req;
  logic [3:0] gnt, rnd;
  logic       gnt_valid, wrap, busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [3:0]  seq [15];

  lfsr_rr_server #(.NREQ(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .rnd       (rnd),
    .wrap      (wrap),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic check_idle(input string tag, input logic [3:0] exp_rnd);
    check_eq({tag, ".gnt"}, 32'(gnt), 0);
    check_eq({tag, ".gv"}, 32'(gnt_valid), 0);
    check_eq({tag, ".wrap"}, 32'(wrap), 0);
    check_eq({tag, ".rnd"}, 32'(rnd), 32'(exp_rnd));
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_gnt,
                             input logic [3:0] exp_rnd, input logic exp_wrap);
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check_eq({tag, ".gv"}, 32'(gnt_valid), 1);
    check_eq({tag, ".rnd"}, 32'(rnd), 32'(exp_rnd));
    check_eq({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  initial begin
    seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    reset = 1'b0; clr = 1'b0; en = 1'b1; seed_load = 1'b0;
    seed = 4'h0; req = 4'h0;
    step();
    step();
    check_idle("rst", 4'h0);
    check_eq("rst.busy", 32'(busy), 0);

    // Single requester: full period, wrap on the 15th grant.
    reset = 1'b1;
    req = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      step();
      check_grant($sformatf("t1.g%0d", i), 4'b0001, seq[i % 15], i == 14);
    end
    req = 4'b0000;
    step();
    check_idle("t1.drop", 4'h1);

    // All requesters: round-robin rotation.
    req = 4'b1111;
    do_reset();
    check_idle("t2.rst", 4'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      check_grant($sformatf("t2.g%0d", i), 4'(1 << (i % 4)), seq[i], 1'b0);
    end

    // Zero seed maps to 0001; first grant two edges after seed_load.
    req = 4'b0000;
    do_reset();
    seed = 4'b0000; seed_load = 1'b1;
    step();
    check_eq("t3.busy", 32'(busy), 1);
    check_idle("t3.k", 4'h0);
    seed_load = 1'b0; req = 4'b0100;
    step();
    check_eq("t3.busy1", 32'(busy), 0);
    check_idle("t3.k1", 4'h0);
    step();
    check_grant("t3.k2", 4'b0100, 4'b0001, 1'b0);

    // Seed 1010 with requests at the same edge.
    req = 4'b0000;
    do_reset();
    seed = 4'b1010; seed_load = 1'b1; req = 4'b0011;
    step();
    check_idle("t4.k", 4'h0);
    check_eq("t4.busy", 32'(busy), 1);
    seed_load = 1'b0;
    step();
    check_idle("t4.k1", 4'h0);
    step();
    check_grant("t4.k2", 4'b0001, 4'b1010, 1'b0);
    step();
    check_grant("t4.k3", 4'b0010, 4'b0101, 1'b0);

    // clr mid-run: pointer, LFSR and wrap counter restart.
    req = 4'b1111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      check_grant($sformatf("t5.g%0d", i), 4'(1 << (i % 4)), seq[i], 1'b0);
    end
    clr = 1'b1;
    step();
    check_idle("t5.clr", seq[4]);
    clr = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check_grant($sformatf("t5.c%0d", i), 4'(1 << (i % 4)), seq[i], i == 14);
    end

    // en low freezes the LFSR; reset mid-run clears everything.
    req = 4'b0001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_grant($sformatf("t6.g%0d", i), 4'b0001, seq[i], 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle($sformatf("t6.off%0d", i), seq[2]);
    end
    en = 1'b1;
    step();
    check_grant("t6.resume", 4'b0001, seq[3], 1'b0);
    step();
    check_grant("t6.resume2", 4'b0001, seq[4], 1'b0);
    reset = 1'b0;
    step();
    check_idle("t6.rst", 4'h0);
    check_eq("t6.busy", 32'(busy), 0);
    reset = 1'b1;
    step();
    check_grant("t6.first", 4'b0001, 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
